// File: rtl/oh_counter_match.sv
// oh_counter_match: compare/capture stage (match pulses, PWM, timestamp capture, sticky maskable irq) fed by an upstream counter's count/wraparound
module oh_counter_match #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] count,
  input  logic         wraparound,
  input  logic         cmp_wr,
  input  logic         cmp_sel,
  input  logic [N-1:0] cmp_data,
  input  logic         capture_in,
  input  logic [3:0]   irq_clear,
  input  logic [3:0]   irq_mask,
  output logic         match0,
  output logic         match1,
  output logic         pwm,
  output logic [N-1:0] capture_data,
  output logic         capture_valid,
  output logic         capture_ovf,
  output logic [3:0]   status,
  output logic         irq
);
  logic [N-1:0] cmp0, cmp1;
  logic eq0, eq1, eq0_q, eq1_q, wrap_q, cap_q;
  logic ev0, ev1, evw, evc;
  always_comb begin
    eq0 = count == cmp0;
    eq1 = count == cmp1;
    ev0 = eq0 & ~eq0_q;
    ev1 = eq1 & ~eq1_q;
    evw = wraparound & ~wrap_q;
    evc = capture_in & ~cap_q;
    irq = |(status & irq_mask);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp0          <= '0;
      cmp1          <= '1;
      eq0_q         <= 1'b1;
      eq1_q         <= 1'b1;
      wrap_q        <= 1'b1;
      cap_q         <= 1'b1;
      match0        <= 1'b0;
      match1        <= 1'b0;
      pwm           <= 1'b0;
      capture_data  <= '0;
      capture_valid <= 1'b0;
      capture_ovf   <= 1'b0;
      status        <= '0;
    end else begin
      if (cmp_wr && !cmp_sel) cmp0 <= cmp_data;
      if (cmp_wr && cmp_sel) cmp1 <= cmp_data;
      eq0_q         <= eq0;
      eq1_q         <= eq1;
      wrap_q        <= wraparound;
      cap_q         <= capture_in;
      match0        <= ev0;
      match1        <= ev1;
      pwm           <= ev1 ? 1'b0 : (ev0 | pwm);
      if (evc) capture_data <= count;
      capture_valid <= evc;
      capture_ovf   <= ((evc & status[3]) | capture_ovf) & ~irq_clear[3];
      status        <= {evc, evw, ev1, ev0} | (status & ~irq_clear);
    end
  end
endmodule

// File: tb/tb_oh_counter_match.sv
// tb_oh_counter_match: directed table-driven bench for oh_counter_match (N=8)
module tb_oh_counter_match;
  logic clk = 1'b0;
  logic reset, wraparound, cmp_wr, cmp_sel, capture_in;
  logic [7:0] count, cmp_data, capture_data;
  logic [3:0] irq_clear, irq_mask, status;
  logic match0, match1, pwm, capture_valid, capture_ovf, irq;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  oh_counter_match #(.N(8)) dut (
    .clk(clk), .reset(reset), .count(count), .wraparound(wraparound),
    .cmp_wr(cmp_wr), .cmp_sel(cmp_sel), .cmp_data(cmp_data),
    .capture_in(capture_in), .irq_clear(irq_clear), .irq_mask(irq_mask),
    .match0(match0), .match1(match1), .pwm(pwm), .capture_data(capture_data),
    .capture_valid(capture_valid), .capture_ovf(capture_ovf),
    .status(status), .irq(irq)
  );
  typedef struct {
    logic rst; logic [7:0] cnt; logic wrap, wr, sel; logic [7:0] data;
    logic cap; logic [3:0] clr, mask;
    logic m0, m1, pwm; logic [7:0] cd; logic cv, ovf; logic [3:0] st; logic irq;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(int rst, int cnt, int wrap, int wr, int sel, int data,
                              int cap, int clr, int mask, int m0, int m1, int p,
                              int cd, int cv, int ovf, int st, int iq);
    vec_t r;
    r.rst = 1'(rst); r.cnt = 8'(cnt); r.wrap = 1'(wrap); r.wr = 1'(wr);
    r.sel = 1'(sel); r.data = 8'(data); r.cap = 1'(cap); r.clr = 4'(clr);
    r.mask = 4'(mask); r.m0 = 1'(m0); r.m1 = 1'(m1); r.pwm = 1'(p);
    r.cd = 8'(cd); r.cv = 1'(cv); r.ovf = 1'(ovf); r.st = 4'(st); r.irq = 1'(iq);
    return r;
  endfunction
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    reset = v.rst; count = v.cnt; wraparound = v.wrap; cmp_wr = v.wr;
    cmp_sel = v.sel; cmp_data = v.data; capture_in = v.cap;
    irq_clear = v.clr; irq_mask = v.mask;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input int cnt, input int wr, input int sel, input int data);
    apply(mk(0, cnt, 0, wr, sel, data, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    // rst cnt wrap wr sel data cap clr mask | m0 m1 pwm cd cv ovf st irq
    tbl.push_back(mk(1,   0,0,0,0,0,0, 0, 0, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0,   0,0,0,0,0,0, 0, 1, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0,   3,0,1,0,5,0, 0, 1, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0,   4,0,0,0,0,0, 0, 1, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0,   5,0,0,0,0,0, 0, 1, 1,0,1, 0,0,0, 1,1));
    tbl.push_back(mk(0,   5,0,0,0,0,0, 0, 1, 0,0,1, 0,0,0, 1,1));
    tbl.push_back(mk(0,   5,0,0,0,0,0, 0, 1, 0,0,1, 0,0,0, 1,1));
    tbl.push_back(mk(0,   6,0,0,0,0,0, 0, 1, 0,0,1, 0,0,0, 1,1));
    tbl.push_back(mk(0,   6,0,0,0,0,0, 0, 0, 0,0,1, 0,0,0, 1,0));
    tbl.push_back(mk(0,   6,0,0,0,0,0, 1, 1, 0,0,1, 0,0,0, 0,0));
    tbl.push_back(mk(0,   7,0,1,1,6,0, 0, 1, 0,0,1, 0,0,0, 0,0));
    tbl.push_back(mk(0,   8,0,1,0,2,0, 0, 1, 0,0,1, 0,0,0, 0,0));
    tbl.push_back(mk(0,   6,0,0,0,0,0, 0, 1, 0,1,0, 0,0,0, 2,0));
    tbl.push_back(mk(0,   7,0,0,0,0,0, 0, 1, 0,0,0, 0,0,0, 2,0));
    tbl.push_back(mk(0,   2,0,0,0,0,0, 0, 1, 1,0,1, 0,0,0, 3,1));
    tbl.push_back(mk(0,   3,0,0,0,0,0, 0, 1, 0,0,1, 0,0,0, 3,1));
    tbl.push_back(mk(0,   6,0,0,0,0,0, 0, 1, 0,1,0, 0,0,0, 3,1));
    tbl.push_back(mk(0,   6,0,0,0,0,0, 3,15, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 254,0,0,0,0,0, 0,15, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 255,1,0,0,0,0, 0,15, 0,0,0, 0,0,0, 4,1));
    tbl.push_back(mk(0,   0,0,0,0,0,0, 0,15, 0,0,0, 0,0,0, 4,1));
    tbl.push_back(mk(0, 255,1,0,0,0,0, 4,15, 0,0,0, 0,0,0, 4,1));
    tbl.push_back(mk(0,   0,0,0,0,0,0, 4,15, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0,  17,0,0,0,0,1, 0,15, 0,0,0,17,1,0, 8,1));
    tbl.push_back(mk(0,  18,0,0,0,0,0, 0,15, 0,0,0,17,0,0, 8,1));
    tbl.push_back(mk(0,  40,0,0,0,0,1, 0,15, 0,0,0,40,1,1, 8,1));
    tbl.push_back(mk(0,  41,0,0,0,0,0, 0,15, 0,0,0,40,0,1, 8,1));
    tbl.push_back(mk(0,  41,0,0,0,0,0, 8,15, 0,0,0,40,0,0, 0,0));
    tbl.push_back(mk(0,  50,0,0,0,0,1, 0,15, 0,0,0,50,1,0, 8,1));
    tbl.push_back(mk(0,  51,0,0,0,0,0, 0,15, 0,0,0,50,0,0, 8,1));
    tbl.push_back(mk(0,  60,0,0,0,0,1, 8,15, 0,0,0,60,1,0, 8,1));
    tbl.push_back(mk(0,  61,0,0,0,0,0, 8,15, 0,0,0,60,0,0, 0,0));
    tbl.push_back(mk(0,   9,0,0,0,0,0, 0,15, 0,0,0,60,0,0, 0,0));
    tbl.push_back(mk(0,   9,0,1,1,9,0, 0,15, 0,0,0,60,0,0, 0,0));
    tbl.push_back(mk(0,   9,0,0,0,0,0, 0,15, 0,1,0,60,0,0, 2,1));
    tbl.push_back(mk(0,   9,0,0,0,0,0, 0,15, 0,0,0,60,0,0, 2,1));
    tbl.push_back(mk(0,   9,0,0,0,0,0, 0,15, 0,0,0,60,0,0, 2,1));
    tbl.push_back(mk(0,   2,1,0,0,0,1, 0,15, 1,0,1, 2,1,0,15,1));
    tbl.push_back(mk(1,   2,1,0,0,0,1, 0,15, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0,   0,0,0,0,0,0, 0,15, 0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(0, 255,0,0,0,0,0, 0,15, 0,1,0, 0,0,0, 2,1));
    tbl.push_back(mk(0,   1,0,0,0,0,0, 0,15, 0,0,0, 0,0,0, 2,1));
    tbl.push_back(mk(0,   0,0,0,0,0,0, 0,15, 1,0,1, 0,0,0, 3,1));
    @(negedge clk);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      chk("match0", i, 8'(match0), 8'(tbl[i].m0));
      chk("match1", i, 8'(match1), 8'(tbl[i].m1));
      chk("pwm", i, 8'(pwm), 8'(tbl[i].pwm));
      chk("capture_data", i, capture_data, tbl[i].cd);
      chk("capture_valid", i, 8'(capture_valid), 8'(tbl[i].cv));
      chk("capture_ovf", i, 8'(capture_ovf), 8'(tbl[i].ovf));
      chk("status", i, 8'(status), 8'(tbl[i].st));
      chk("irq", i, 8'(irq), 8'(tbl[i].irq));
    end
    drv(200, 1, 1, 6);
    drv(200, 1, 0, 2);
    drv(6, 0, 0, 0);
    chk("pwm_preclear", 0, 8'(pwm), 8'd0);
    for (int lap = 0; lap < 2; lap++)
      for (int c = 0; c < 256; c++) begin
        drv(c, 0, 0, 0);
        chk("pwm_lap", c, 8'(pwm), 8'(c >= 2 && c < 6));
        chk("match0_lap", c, 8'(match0), 8'(c == 2));
        chk("match1_lap", c, 8'(match1), 8'(c == 6));
      end
    drv(255, 1, 0, 4);
    drv(255, 1, 1, 4);
    for (int c = 0; c < 10; c++) begin
      drv(c, 0, 0, 0);
      chk("pwm_eq", c, 8'(pwm), 8'd0);
      chk("match0_eq", c, 8'(match0), 8'(c == 4));
      chk("match1_eq", c, 8'(match1), 8'(c == 4));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oh_counter_match.md
# oh_counter_match

Compare/capture stage placed directly downstream of the generic counter. It consumes the counter's `count` and `wraparound` outputs and produces:
- one-cycle match pulses against two programmable compare registers;
- a PWM waveform, set on compare 0 and cleared on compare 1;
- a timestamp capture register;
- sticky, maskable interrupt status.

All outputs are registered except `irq`.

## Interface
Parameters:
- `N`, 32, counter/compare width; must match the upstream counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `count`  in  N  counter value from upstream counter
- `wraparound`  in  1  wrap indicator from upstream counter
- `cmp_wr`  in  1  write strobe for a compare register
- `cmp_sel`  in  1  compare register select (0 = cmp0, 1 = cmp1)
- `cmp_data`  in  N  compare write data
- `capture_in`  in  1  synchronous capture request (level, sampled every cycle)
- `irq_clear`  in  4  write-1-to-clear for `status[3:0]` and `capture_ovf`
- `irq_mask`  in  4  per-bit interrupt enable
- `match0`  out  1  one-cycle pulse, count reached cmp0
- `match1`  out  1  one-cycle pulse, count reached cmp1
- `pwm`  out  1  PWM output
- `capture_data`  out  N  last captured count
- `capture_valid`  out  1  one-cycle pulse, `capture_data` updated
- `capture_ovf`  out  1  sticky, capture occurred while `status[3]` already set
- `status`  out  4  sticky event flags: [0] match0, [1] match1, [2] wrap, [3] capture
- `irq`  out  1  `|(status & irq_mask)`, combinational from flops and mask

## Operation

Compare registers:
- `cmp0` resets to 0; `cmp1` resets to all ones.
- `cmp_wr` loads `cmp_data` into the register selected by `cmp_sel` at the clock edge.

Match detection:
- `eq_k = (count == cmp_k)` is computed against the current register value.
- `eq_k_q` is `eq_k` registered; it resets to 1.
- `match_k` is registered as `eq_k & ~eq_k_q`. It pulses once when equality is first reached.
- It does not repeat while `count` holds at the compare value, e.g. a stalled or non-autowrap counter.
- If a compare write makes the new value equal the held `count`, `match_k` pulses once on the following cycle.

Wrap detection:
- `wrap_q` resets to 1.
- The wrap event is `wraparound & ~wrap_q`, a rising edge only.

PWM:
- Sets on the match0 event and clears on the match1 event.
- If both events occur in the same cycle, clear wins and `pwm` = 0.

Capture:
- The event is a rising edge of `capture_in`; the edge-detect flop resets to 1.
- On the event, `capture_data <= count` and `capture_valid` pulses.
- If `status[3]` is already 1 and not being cleared that cycle, `capture_ovf` sets.

Status:
- Each bit sets on its event.
- `irq_clear[k]` clears bit k; `irq_clear[3]` also clears `capture_ovf`.
- Set wins over clear in the same cycle.

Reset:
- Every output is 0.
- `capture_data` is 0.
- Edge/equality history flops are 1, so no events fire from reset state.

## Timing
- Event latency: an input sampled at edge t appears on `match*`, `capture_valid`, `pwm` and `status` after edge t, i.e. in cycle t+1.
- `capture_data` holds the `count` value present in cycle t, valid in cycle t+1, coincident with `capture_valid`.
- `irq` follows `status` combinationally.
  - `irq` rises in the same cycle that `status` rises.
  - A mask change affects `irq` in the same cycle.
- Compare writes take effect for equality checks in the cycle after the write edge.
- Reset asserted mid-operation: on the next edge all state returns to reset values, and pending events are dropped.
- No handshake on capture. A new capture overwrites `capture_data` unconditionally; overrun is only flagged.
- Width rule: comparisons are full N-bit unsigned equality; no arithmetic is performed.

## Test plan
- **Match once:** N=8, cmp0=5, count steps 3,4,5,5,5,6 → `match0` high exactly one cycle (the cycle after count=5 first appears), `status[0]`=1, `irq`=1 with `irq_mask`=4'b0001.
- **PWM:** cmp0=2, cmp1=6, count 0..255 autowrapping → `pwm` high from cycle after count=2 through cycle of count=6, low after; period 256. Then cmp0=cmp1=4 → `pwm` stays 0.
- **Wrap/status clear:** count 254,255,0 with `wraparound` high at 255 → `status[2]` sets. Then `irq_clear`=4'b0100 asserted in the same cycle as a new wrap event → `status[2]` stays 1 (set wins).
- **Capture/overrun:** `capture_in` pulse at count=17 → `capture_data`=17, `capture_valid` one cycle. Second pulse at count=40 without clear → `capture_data`=40, `capture_ovf`=1. `irq_clear`=4'b1000 → `status[3]` and `capture_ovf` go to 0.
- **Compare write onto held count:** count held at 9, write cmp1=9 → `match1` pulses exactly once, in the second cycle after the write edge.
- **Reset mid-run:** assert `reset` with `pwm`=1 and `status`=4'hF → next cycle all outputs 0, cmp0=0, cmp1=8'hFF. Count at 0 after reset → no `match0` pulse.
